// File: rtl/pll_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_pkg
// Purpose  : Shared frame layout, FSM states and frame pack helper for the
//            PLL40 serial configuration loader.
// Revision : 1.0
// ============================================================================
package pll_cfg_pkg;

    localparam int FRAME_W = 34;

    // One counter serves both the reset hold (<=16 bit) and lock timeout (<=24 bit)
    localparam int c_cnt_w = 24;

    // Field layout, MSB first: DIVR at the top of the frame, PLLOUT_SELECT at the bottom
    localparam int c_divr_w     = 4;
    localparam int c_divr_lsb   = 30;
    localparam int c_divf_w     = 7;
    localparam int c_divf_lsb   = 23;
    localparam int c_divq_w     = 3;
    localparam int c_divq_lsb   = 20;
    localparam int c_filt_w     = 3;
    localparam int c_filt_lsb   = 17;
    localparam int c_fbpath_w   = 3;
    localparam int c_fbpath_lsb = 14;
    localparam int c_damfb_lsb  = 13;
    localparam int c_damrel_lsb = 12;
    localparam int c_fdafb_w    = 4;
    localparam int c_fdafb_lsb  = 8;
    localparam int c_fdarel_w   = 4;
    localparam int c_fdarel_lsb = 4;
    localparam int c_srdiv_w    = 2;
    localparam int c_srdiv_lsb  = 2;
    localparam int c_pllout_w   = 2;
    localparam int c_pllout_lsb = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_WAIT_LOCK = 3'd4,
        ST_FIN       = 3'd5
    } state_t;

    function automatic logic [FRAME_W-1:0] pack_cfg(
        input logic [c_divr_w-1:0]   divr,
        input logic [c_divf_w-1:0]   divf,
        input logic [c_divq_w-1:0]   divq,
        input logic [c_filt_w-1:0]   filter_range,
        input logic [c_fbpath_w-1:0] feedback_path,
        input logic                  dam_feedback,
        input logic                  dam_relative,
        input logic [c_fdafb_w-1:0]  fda_feedback,
        input logic [c_fdarel_w-1:0] fda_relative,
        input logic [c_srdiv_w-1:0]  shiftreg_div_mode,
        input logic [c_pllout_w-1:0] pllout_select
    );
        logic [FRAME_W-1:0] v;
        v = '0;
        v[c_divr_lsb   +: c_divr_w]   = divr;
        v[c_divf_lsb   +: c_divf_w]   = divf;
        v[c_divq_lsb   +: c_divq_w]   = divq;
        v[c_filt_lsb   +: c_filt_w]   = filter_range;
        v[c_fbpath_lsb +: c_fbpath_w] = feedback_path;
        v[c_damfb_lsb]                = dam_feedback;
        v[c_damrel_lsb]               = dam_relative;
        v[c_fdafb_lsb  +: c_fdafb_w]  = fda_feedback;
        v[c_fdarel_lsb +: c_fdarel_w] = fda_relative;
        v[c_srdiv_lsb  +: c_srdiv_w]  = shiftreg_div_mode;
        v[c_pllout_lsb +: c_pllout_w] = pllout_select;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_if
// Purpose  : Request/response bus between the system controller and the
//            PLL configuration loader.
// Revision : 1.0
// ============================================================================
interface pll_cfg_if #(
    parameter int FRAME_W = pll_cfg_pkg::FRAME_W
) ();

    logic               start;
    logic [FRAME_W-1:0] cfg_data;
    logic               busy;
    logic               done;
    logic               error;
    logic [FRAME_W-1:0] rd_data;

    modport master (
        output start,
        output cfg_data,
        input  busy,
        input  done,
        input  error,
        input  rd_data
    );

    modport slave (
        input  start,
        input  cfg_data,
        output busy,
        output done,
        output error,
        output rd_data
    );

endinterface
`default_nettype wire

// File: rtl/pll_cfg_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_sclk_gen
// Purpose  : SCLK generator: CLK_DIV clocks low then CLK_DIV clocks high per
//            bit, rise/fall strobes and a strobe on the fall of the last bit.
// Revision : 1.0
// ============================================================================
module pll_cfg_sclk_gen #(
    parameter int CLK_DIV = 4,
    parameter int NBITS   = 34
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall,
    output logic o_last
);

    localparam int                 c_bit_w     = $clog2(NBITS + 1);
    localparam logic [7:0]         c_half_last = 8'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_nbits     = c_bit_w'(NBITS);

    logic [7:0]         r_div;
    logic [c_bit_w-1:0] r_bits;
    logic               r_sclk;
    logic               w_half_end;

    assign w_half_end = i_en & (r_div == c_half_last);

    // Strobes fire in the cycle whose closing edge toggles sclk
    assign o_rise = w_half_end & ~r_sclk;
    assign o_fall = w_half_end &  r_sclk;
    assign o_last = o_fall & (r_bits == c_nbits);
    assign o_sclk = r_sclk;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
            r_bits <= '0;
        end else if (w_half_end) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
                r_bits <= r_bits + c_bit_w'(1);
            end
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : pll_cfg_loader
// Purpose  : Serial configuration master for the PLL40 SCLK/SDI/SDO port with
//            RESETB hold, readback capture and LOCK wait with timeout.
// Revision : 1.0
// ============================================================================
module pll_cfg_loader
    import pll_cfg_pkg::*;
#(
    parameter int FRAME_W      = pll_cfg_pkg::FRAME_W,
    parameter int CLK_DIV      = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic     clk,
    input  logic     rst,
    pll_cfg_if.slave host,
    output logic     pll_sclk,
    output logic     pll_sdi,
    input  logic     pll_sdo,
    output logic     pll_resetb,
    input  logic     pll_lock,
    output logic     locked
);

    localparam logic [c_cnt_w-1:0] c_rst_last  = c_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] r_rd_data;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sdi;
    logic               r_error;
    logic               r_lock_meta;
    logic               r_lock_sync;

    logic               w_busy;
    logic               w_done;
    logic               w_resetb;
    logic               w_gen_en;
    logic               w_cnt_run;
    logic               w_rst_end;
    logic               w_lock_end;
    logic               w_sclk;
    logic               w_rise;
    logic               w_fall;
    logic               w_last;

    assign w_rst_end  = (r_cnt == c_rst_last);
    assign w_lock_end = (r_cnt == c_lock_last);

    pll_cfg_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .NBITS   (FRAME_W)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_gen_en),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_resetb  = 1'b0;
        w_gen_en  = 1'b0;
        w_cnt_run = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy   = 1'b0;
                w_resetb = 1'b1;
                if (host.start) begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_cnt_run = 1'b1;
                if (w_rst_end) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_gen_en = 1'b1;
                if (w_last) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_cnt_run = 1'b1;
                if (w_rst_end) begin
                    w_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                w_resetb  = 1'b1;
                w_cnt_run = 1'b1;
                // Lock takes priority when it coincides with the final timeout count
                if (r_lock_sync || w_lock_end) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_busy   = 1'b0;
                w_done   = 1'b1;
                w_resetb = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_busy   = 1'b0;
                w_resetb = 1'b1;
                w_next   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_rd_data   <= '0;
            r_cnt       <= '0;
            r_sdi       <= 1'b0;
            r_error     <= 1'b0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_sync <= r_lock_meta;

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (host.start) begin
                        r_shift <= host.cfg_data;
                        r_error <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_rst_end) begin
                        r_sdi <= r_shift[FRAME_W-1];
                    end
                end
                ST_SHIFT: begin
                    // SDO is captured as SCLK rises; SDI only moves on the falling edge
                    if (w_rise) begin
                        r_shift <= {r_shift[FRAME_W-2:0], pll_sdo};
                    end
                    if (w_fall) begin
                        r_sdi <= r_shift[FRAME_W-1];
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_next == ST_FIN) begin
                        r_error <= ~r_lock_sync;
                    end
                end
                ST_FIN: begin
                    r_rd_data <= r_shift;
                end
                default: begin
                end
            endcase
        end
    end

    assign pll_sclk   = w_sclk;
    assign pll_sdi    = r_sdi & (r_state == ST_SHIFT);
    assign pll_resetb = w_resetb;
    assign locked     = r_lock_sync & w_resetb;

    assign host.busy    = w_busy;
    assign host.done    = w_done;
    assign host.error   = r_error;
    assign host.rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_pll_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_cfg_loader
// Purpose  : Directed and randomized bench for pll_cfg_loader with a bit-level
//            PLL40 SDO/LOCK model and a timing reference derived from the rules.
// Revision : 1.0
// ============================================================================
module tb_pll_cfg_loader;
    import pll_cfg_pkg::*;

    localparam int FW        = 34;
    localparam int CD        = 2;
    localparam int RC        = 16;
    localparam int LT        = 200;
    localparam int SHIFT_CYC = 2 * CD * FW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_sclk;
    logic          pll_sdi;
    logic          pll_sdo;
    logic          pll_resetb;
    logic          pll_lock = 1'b0;
    logic          locked;
    logic [FW-1:0] pll_reg = 34'h1_0000_0001;

    pll_cfg_if #(.FRAME_W(FW)) host_if ();

    pll_cfg_loader #(
        .FRAME_W      (FW),
        .CLK_DIV      (CD),
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host_if),
        .pll_sclk   (pll_sclk),
        .pll_sdi    (pll_sdi),
        .pll_sdo    (pll_sdo),
        .pll_resetb (pll_resetb),
        .pll_lock   (pll_lock),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // PLL40 test-port model: frame register shifts SDI in on SCLK rise, MSB drives SDO
    assign pll_sdo = pll_reg[FW-1];
    always @(posedge pll_sclk) pll_reg <= {pll_reg[FW-2:0], pll_sdi};

    // LOCK model: asserts lock_delay clocks after RESETB rises (0 = never)
    int lock_delay = 0;
    int since_rise = 0;
    always @(negedge clk) begin
        if (pll_resetb !== 1'b1) begin
            since_rise = 0;
            pll_lock   = 1'b0;
        end else begin
            since_rise++;
            if (lock_delay > 0 && since_rise >= lock_delay) pll_lock = 1'b1;
        end
    end

    // Pin monitor
    int            cyc = 0;
    int            rise_cnt, sclk_hi, bad_period, sdi_bad, rule_bad;
    int            busy_cnt, done_cnt, done_rel, last_rise, rb_rise;
    logic [FW-1:0] sdi_word;
    logic          prev_sclk = 1'b0, prev_sdi = 1'b0, prev_resetb = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (pll_sclk === 1'b1) sclk_hi++;
        if (pll_sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_cnt++;
            sdi_word = {sdi_word[FW-2:0], pll_sdi};
            if (rise_cnt > 1 && (cyc - last_rise) != 2 * CD) bad_period++;
            last_rise = cyc;
        end
        if (pll_sdi !== prev_sdi && (pll_sclk === 1'b1 || prev_sclk === 1'b1) &&
            !(prev_sclk === 1'b1 && pll_sclk === 1'b0)) sdi_bad++;
        if (host_if.busy === 1'b0 && (pll_sclk !== 1'b0 || pll_sdi !== 1'b0)) rule_bad++;
        if (locked === 1'b1 && pll_resetb !== 1'b1) rule_bad++;
        if (pll_resetb === 1'b1 && prev_resetb === 1'b0) rb_rise = cyc;
        if (host_if.busy === 1'b1) busy_cnt++;
        if (host_if.done === 1'b1) begin
            done_cnt++;
            done_rel = cyc - rb_rise;
        end
        prev_sclk   = pll_sclk;
        prev_sdi    = pll_sdi;
        prev_resetb = pll_resetb;
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [FW-1:0] exp_cfg, exp_rd, cfg_a, cfg_b;
    int            exp_rel;
    logic          exp_err, exp_locked;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] rand_cfg();
        return pack_cfg(4'($urandom), 7'($urandom), 3'($urandom), 3'($urandom),
                        3'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                        4'($urandom), 2'($urandom), 2'($urandom));
    endfunction

    task automatic clear_stats();
        rise_cnt = 0; sclk_hi = 0; bad_period = 0; sdi_bad = 0; rule_bad = 0;
        busy_cnt = 0; done_cnt = 0; done_rel = -1; sdi_word = '0;
    endtask

    // Reference: readback is the frame the PLL holds now; lock is seen two
    // clocks after it asserts and wins ties with the final timeout count.
    task automatic start_run(input logic [FW-1:0] cfg, input int d);
        lock_delay = d;
        exp_cfg    = cfg;
        exp_rd     = pll_reg;
        exp_err    = !(d > 0 && d + 2 <= LT);
        exp_rel    = exp_err ? LT : d + 2;
        exp_locked = (d > 0);
        clear_stats();
        host_if.cfg_data = cfg;
        host_if.start    = 1'b1;
        tick();
        host_if.start    = 1'b0;
    endtask

    task automatic finish_run(input string t);
        int n = 0;
        while (host_if.done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check({t, ".done_seen"}, 64'(host_if.done), 64'(1));
        check({t, ".error"}, 64'(host_if.error), 64'(exp_err));
        tick();
        check({t, ".rd_data"}, 64'(host_if.rd_data), 64'(exp_rd));
        check({t, ".busy_after"}, 64'(host_if.busy), 64'(0));
        check({t, ".locked"}, 64'(locked), 64'(exp_locked));
        check({t, ".sdi_stream"}, 64'(sdi_word), 64'(exp_cfg));
        check({t, ".sclk_rises"}, 64'(rise_cnt), 64'(FW));
        check({t, ".sclk_high"}, 64'(sclk_hi), 64'(CD * FW));
        check({t, ".bad_period"}, 64'(bad_period), 64'(0));
        check({t, ".sdi_stable"}, 64'(sdi_bad), 64'(0));
        check({t, ".idle_rules"}, 64'(rule_bad), 64'(0));
        check({t, ".resetb_to_done"}, 64'(done_rel), 64'(exp_rel));
        check({t, ".busy_len"}, 64'(busy_cnt), 64'(2 * RC + SHIFT_CYC + exp_rel));
        check({t, ".done_pulses"}, 64'(done_cnt), 64'(1));
    endtask

    initial begin
        int n;
        host_if.start    = 1'b0;
        host_if.cfg_data = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("RST.busy", 64'(host_if.busy), 64'(0));
        check("RST.done", 64'(host_if.done), 64'(0));
        check("RST.error", 64'(host_if.error), 64'(0));
        check("RST.rd_data", 64'(host_if.rd_data), 64'(0));
        check("RST.sclk", 64'(pll_sclk), 64'(0));
        check("RST.sdi", 64'(pll_sdi), 64'(0));
        check("RST.resetb", 64'(pll_resetb), 64'(1));
        check("RST.locked", 64'(locked), 64'(0));
        rst = 1'b0;
        tick();

        cfg_a = 34'h2_A5A5_5A5A;
        start_run(cfg_a, 50);
        finish_run("A");
        check("A.rd_const", 64'(host_if.rd_data), 64'h1_0000_0001);
        check("A.busy_const", 64'(busy_cnt), 64'(16 + 136 + 16 + 52));

        // Started on the cycle after done; the model loops frame A back
        cfg_b = rand_cfg();
        start_run(cfg_b, int'($urandom_range(1, 150)));
        finish_run("B2B");
        check("B2B.loopback", 64'(host_if.rd_data), 64'(cfg_a));

        start_run(rand_cfg(), 0);
        finish_run("TIMEOUT");
        start_run(rand_cfg(), 198);
        finish_run("LOCK_AT_LAST");
        start_run(rand_cfg(), 199);
        finish_run("LOCK_TOO_LATE");

        start_run(rand_cfg(), 20);
        repeat (RC + 20) tick();
        host_if.cfg_data = ~exp_cfg;
        host_if.start    = 1'b1;
        tick();
        host_if.start    = 1'b0;
        finish_run("IGNORED_START");

        start_run(rand_cfg(), 30);
        n = 0;
        while (rise_cnt < 10 && n < 500) begin
            tick();
            n++;
        end
        check("MIDRST.edge10", 64'(rise_cnt), 64'(10));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("MIDRST.sclk", 64'(pll_sclk), 64'(0));
        check("MIDRST.sdi", 64'(pll_sdi), 64'(0));
        check("MIDRST.resetb", 64'(pll_resetb), 64'(1));
        check("MIDRST.busy", 64'(host_if.busy), 64'(0));
        check("MIDRST.rd_data", 64'(host_if.rd_data), 64'(0));
        repeat (20) tick();
        check("MIDRST.no_done", 64'(done_cnt), 64'(0));
        check("MIDRST.idle", 64'(host_if.busy), 64'(0));

        start_run(rand_cfg(), 40);
        finish_run("AFTER_RST");

        for (int k = 0; k < 3; k++) begin
            start_run(rand_cfg(), int'($urandom_range(1, 190)));
            finish_run("RANDOM");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_cfg_loader.md
Name: pll_cfg_loader

Overview:
- Serial configuration master for the PLL40 test/dynamic-configuration port (SCLK/SDI/SDO) plus RESETB/LOCK sequencing.
- On request, holds the PLL in reset and shifts a full configuration frame into the PLL. It captures the previous frame returned on SDO, releases reset and waits for LOCK with a timeout.
- Sits in the clock/reset block between the system controller (register interface) and the PLL40 instance built with TEST_MODE=1.

Parameters:
- FRAME_W, 34, configuration frame length in bits; field layout defined in the shared package.
- CLK_DIV, 4, system clocks per SCLK half-period; legal range 1..255.
- RST_CYCLES, 16, clocks RESETB is held low before the first SCLK edge and after the last one; legal range 1..65535.
- LOCK_TIMEOUT, 100000, clocks allowed from RESETB release until LOCK; legal range 1..2^24-1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cfg_data  in  FRAME_W  frame to load; captured on the accepted start cycle.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle pulse at the end of a sequence.
- error  out  1  valid with done: 1 = lock timeout; 0 = locked.
- rd_data  out  FRAME_W  frame shifted out of SDO during the last sequence; updated only on done.
- pll_sclk  out  1  to PLL40 SCLK.
- pll_sdi  out  1  to PLL40 SDI.
- pll_sdo  in  1  from PLL40 SDO.
- pll_resetb  out  1  to PLL40 RESETB; active-low.
- pll_lock  in  1  from PLL40 LOCK; asynchronous, double-flopped internally.
- locked  out  1  synchronized pll_lock, gated by pll_resetb.

Behaviour:
- Reset values:
  - busy=0, done=0, error=0, rd_data=0.
  - pll_sclk=0, pll_sdi=0.
  - pll_resetb=1: PLL runs its current configuration.
  - locked=0; state=IDLE; all counters 0.
- IDLE:
  - start=1 captures cfg_data into the shift register and goes to HOLD.
  - start in any other state is ignored. No queuing; no error.
- HOLD:
  - pll_resetb=0.
  - Count RST_CYCLES clocks, then go to SHIFT.
- SHIFT:
  - pll_sdi = shift_reg[FRAME_W-1], presented with pll_sclk low. Bits go out MSB first.
  - pll_sclk rises after CLK_DIV clocks low and stays high CLK_DIV clocks, giving period 2*CLK_DIV.
  - In the clock cycle where pll_sclk goes 0->1, sample pll_sdo into the LSB of the shift register and shift left by one.
  - pll_sdi changes only on the 1->0 SCLK transition, which guarantees CLK_DIV clocks of setup and hold.
  - After exactly FRAME_W rising edges, the final high phase completes and pll_sclk returns to 0. The shift register then holds the readback frame. Go to SETTLE.
- SETTLE:
  - pll_resetb stays 0 for RST_CYCLES clocks, then pll_resetb=1 and go to WAIT_LOCK.
- WAIT_LOCK:
  - Timeout counter starts at 0 on entry.
  - If lock_sync=1, go to FIN with error=0.
  - If the counter reaches LOCK_TIMEOUT-1 without lock, go to FIN with error=1.
  - If lock and timeout occur in the same cycle, lock wins.
- FIN (single cycle):
  - done=1, busy=0 in this cycle.
  - rd_data <= shift register; error latched.
  - Return to IDLE.
- error holds its value until the next accepted start, which clears it.
- pll_sclk is 0 in every state except SHIFT.
- pll_sdi is 0 outside SHIFT.
- locked = lock_sync & pll_resetb. It drops to 0 on the same clock pll_resetb falls.
- rst mid-sequence: return to IDLE next clock and apply all reset values. pll_resetb returns to 1, so the PLL restarts with whatever partial frame it holds. No done pulse.
- Counters are sized to their parameters' legal ranges; no wrap is reachable.

Decomposition:
- Package pll_cfg_pkg holds:
  - FRAME_W;
  - field offsets/widths for DIVR[3:0], DIVF[6:0], DIVQ[2:0], FILTER_RANGE[2:0], FEEDBACK_PATH[2:0], DELAY_ADJUSTMENT_MODE_FEEDBACK, DELAY_ADJUSTMENT_MODE_RELATIVE, FDA_FEEDBACK[3:0], FDA_RELATIVE[3:0], SHIFTREG_DIV_MODE[1:0], PLLOUT_SELECT[1:0] (MSB first in that order);
  - a pack function building cfg_data from fields;
  - the state enum.
- One sub-module, pll_cfg_sclk_gen: CLK_DIV half-period counter producing sclk, a rise strobe and a fall strobe, with enable and bit-count done.

Test Plan:
- CLK_DIV=2, FRAME_W=34, cfg_data=34'h2_A5A5_5A5A, bit-level PLL SDO model preloaded with 34'h1_0000_0001, lock asserted 50 clocks after RESETB rises:
  - SDI bit sequence equals cfg_data MSB first;
  - exactly 34 SCLK rises, period 4 clocks;
  - rd_data=34'h1_0000_0001;
  - done with error=0;
  - busy high for 16+136+16+lock-latency clocks.
- LOCK_TIMEOUT=200, lock held 0 -> done at exactly 200 clocks after pll_resetb rises; error=1; locked=0.
- Lock asserts on the cycle the timeout counter hits LOCK_TIMEOUT-1 -> error=0.
- start pulsed again during SHIFT with different data -> ignored; SDI stream and rd_data unchanged; one done only.
- rst asserted at SCLK edge 10 -> next clock: sclk=0, sdi=0, pll_resetb=1, busy=0, no done. A following start completes normally.
- Back-to-back: second start on the cycle after done -> accepted. rd_data from the second run equals the first run's cfg_data, because the model loops the frame back.
